// File: rtl/dcmac_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dcmac_reset_sequencer
// Purpose  : Autonomous bring-up and recovery sequencer for the two-port DCMAC
//            GT reset controls. After a start request it pulses the global GT
//            reset and waits (with timeouts) for TX, then RX, reset-done. It
//            retries a bounded number of times before declaring a fault. While
//            running, it watches per-port RX alignment and issues per-port RX
//            datapath resets to recover a lost link.
// Ports    : clk, reset (sync, active-high), start (1-cycle request)
//            tx_reset_done[1:0], rx_reset_done[1:0], rx_aligned[1:0]
//            gt_reset_all, gt_reset_rx_datapath[1:0] (registered resets)
//            ready (RUN), fault (FAULT), retries[3:0]
//            rx_recoveries[31:0] ({port1[15:0], port0[15:0]}, saturating)
// Revision : 1.0 - initial release
// ============================================================================
module dcmac_reset_sequencer #(
    parameter int unsigned PULSE_CYCLES  = 100,
    parameter int unsigned DONE_TIMEOUT  = 1000000,
    parameter int unsigned ALIGN_TIMEOUT = 1000000,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  tx_reset_done,
    input  logic [1:0]  rx_reset_done,
    input  logic [1:0]  rx_aligned,
    output logic        gt_reset_all,
    output logic [1:0]  gt_reset_rx_datapath,
    output logic        ready,
    output logic        fault,
    output logic [3:0]  retries,
    output logic [31:0] rx_recoveries
);

    // Terminal counts: a timer holding *_LAST in a cycle means this is the
    // final cycle of the window.
    localparam logic [31:0] c_PULSE_LAST  = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] c_DONE_LAST   = 32'(DONE_TIMEOUT - 1);
    localparam logic [31:0] c_ALIGN_LAST  = 32'(ALIGN_TIMEOUT - 1);
    localparam logic [3:0]  c_MAX_RETRIES = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PULSE_ALL = 3'd1,
        S_WAIT_TX   = 3'd2,
        S_WAIT_RX   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_timer;
    logic [31:0] w_timer_next;
    logic [3:0]  r_retries;
    logic [3:0]  w_retries_next;
    logic        w_retry;
    logic        r_gt_reset_all;
    logic        w_run_hold;

    // ------------------------------------------------------------------------
    // Main sequencer: next-state, timer and retry bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_retries_next = r_retries;
        w_retry        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next   = S_PULSE_ALL;
                    w_timer_next   = '0;
                    w_retries_next = '0;
                end
            end
            S_PULSE_ALL: begin
                if (r_timer == c_PULSE_LAST) begin
                    w_state_next = S_WAIT_TX;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + 32'd1;
                end
            end
            S_WAIT_TX: begin
                // Done is checked first so it wins over a same-cycle timeout.
                if (tx_reset_done == 2'b11) begin
                    w_state_next = S_WAIT_RX;
                    w_timer_next = '0;
                end else if (r_timer == c_DONE_LAST) begin
                    w_retry = 1'b1;
                end else begin
                    w_timer_next = r_timer + 32'd1;
                end
            end
            S_WAIT_RX: begin
                if (rx_reset_done == 2'b11) begin
                    w_state_next = S_RUN;
                    w_timer_next = '0;
                end else if (r_timer == c_DONE_LAST) begin
                    w_retry = 1'b1;
                end else begin
                    w_timer_next = r_timer + 32'd1;
                end
            end
            S_RUN: begin
                // A fresh start request restarts the whole sequence with a
                // clean retry budget, so it takes precedence over TX loss.
                if (start) begin
                    w_state_next   = S_PULSE_ALL;
                    w_timer_next   = '0;
                    w_retries_next = '0;
                end else if (tx_reset_done != 2'b11) begin
                    w_retry = 1'b1;
                end
            end
            S_FAULT: begin
                if (start) begin
                    w_state_next   = S_PULSE_ALL;
                    w_timer_next   = '0;
                    w_retries_next = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_timer_next = '0;
            end
        endcase

        if (w_retry) begin
            w_timer_next = '0;
            if (r_retries < c_MAX_RETRIES) begin
                w_retries_next = r_retries + 4'd1;
                w_state_next   = S_PULSE_ALL;
            end else begin
                w_state_next = S_FAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_retries      <= '0;
            r_gt_reset_all <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_timer        <= w_timer_next;
            r_retries      <= w_retries_next;
            // Registered from the next state so the pulse lines up exactly
            // with the cycles spent in PULSE_ALL.
            r_gt_reset_all <= (w_state_next == S_PULSE_ALL);
        end
    end

    // Per-port recovery only runs while the sequencer stays in RUN; leaving
    // RUN drops any in-flight per-port pulse and clears the align counters.
    assign w_run_hold = (r_state == S_RUN) && (w_state_next == S_RUN);

    // ------------------------------------------------------------------------
    // Per-port RX alignment watchdog and datapath reset pulse
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [31:0] r_align_cnt;
        logic [31:0] r_pulse_cnt;
        logic        r_pulse;
        logic [15:0] r_rec;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_align_cnt <= '0;
                r_pulse_cnt <= '0;
                r_pulse     <= 1'b0;
                r_rec       <= '0;
            end else if (!w_run_hold) begin
                r_align_cnt <= '0;
                r_pulse_cnt <= '0;
                r_pulse     <= 1'b0;
            end else if (r_pulse) begin
                // Align counter is frozen while this port's pulse is active.
                if (r_pulse_cnt == c_PULSE_LAST) begin
                    r_pulse     <= 1'b0;
                    r_pulse_cnt <= '0;
                end else begin
                    r_pulse_cnt <= r_pulse_cnt + 32'd1;
                end
            end else if (rx_aligned[p]) begin
                r_align_cnt <= '0;
            end else if (r_align_cnt == c_ALIGN_LAST) begin
                r_pulse     <= 1'b1;
                r_pulse_cnt <= '0;
                r_align_cnt <= '0;
                if (r_rec != 16'hFFFF) begin
                    r_rec <= r_rec + 16'd1;
                end
            end else begin
                r_align_cnt <= r_align_cnt + 32'd1;
            end
        end

        assign gt_reset_rx_datapath[p]   = r_pulse;
        assign rx_recoveries[16*p +: 16] = r_rec;
    end

    assign gt_reset_all = r_gt_reset_all;
    assign ready        = (r_state == S_RUN);
    assign fault        = (r_state == S_FAULT);
    assign retries      = r_retries;

endmodule
`default_nettype wire

// File: tb/tb_dcmac_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcmac_reset_sequencer
// Purpose  : Scoreboard bench. Directed stimulus pushes hand-computed output
//            events (cycle + full output snapshot) into a queue; a monitor
//            detects every change on the DUT outputs and pops/compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcmac_reset_sequencer;

    localparam logic [31:0] c_R = 32'h0002_0003;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  tx_reset_done;
    logic [1:0]  rx_reset_done;
    logic [1:0]  rx_aligned;
    logic        gt_reset_all;
    logic [1:0]  gt_reset_rx_datapath;
    logic        ready;
    logic        fault;
    logic [3:0]  retries;
    logic [31:0] rx_recoveries;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int          c;
        logic        gt;
        logic [1:0]  dp;
        logic        rdy;
        logic        flt;
        logic [3:0]  rt;
        logic [31:0] rec;
    } ev_t;

    ev_t exp_q[$];

    dcmac_reset_sequencer #(
        .PULSE_CYCLES (4),
        .DONE_TIMEOUT (16),
        .ALIGN_TIMEOUT(8),
        .MAX_RETRIES  (2)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .tx_reset_done       (tx_reset_done),
        .rx_reset_done       (rx_reset_done),
        .rx_aligned          (rx_aligned),
        .gt_reset_all        (gt_reset_all),
        .gt_reset_rx_datapath(gt_reset_rx_datapath),
        .ready               (ready),
        .fault               (fault),
        .retries             (retries),
        .rx_recoveries       (rx_recoveries)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic ex(input int c, input logic gt, input logic [1:0] dp,
                      input logic rdy, input logic flt, input logic [3:0] rt,
                      input logic [31:0] rec);
        ev_t e;
        e.c = c; e.gt = gt; e.dp = dp; e.rdy = rdy; e.flt = flt; e.rt = rt; e.rec = rec;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: any change of the output snapshot is an event to be checked.
    logic        have_prev = 1'b0;
    logic [40:0] prev_snap;
    logic [40:0] cur_snap;
    ev_t         got_e;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cur_snap = {gt_reset_all, gt_reset_rx_datapath, ready, fault, retries, rx_recoveries};
            if (!have_prev || cur_snap !== prev_snap) begin
                have_prev = 1'b1;
                prev_snap = cur_snap;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d got gt=%b dp=%b rdy=%b flt=%b rt=%0d rec=%h, required none",
                             cyc, gt_reset_all, gt_reset_rx_datapath, ready, fault, retries, rx_recoveries);
                end else begin
                    got_e = exp_q.pop_front();
                    if (got_e.c != cyc || got_e.gt !== gt_reset_all || got_e.dp !== gt_reset_rx_datapath ||
                        got_e.rdy !== ready || got_e.flt !== fault || got_e.rt !== retries ||
                        got_e.rec !== rx_recoveries) begin
                        n_fail++;
                        $display("FAIL event got cyc=%0d gt=%b dp=%b rdy=%b flt=%b rt=%0d rec=%h / required cyc=%0d gt=%b dp=%b rdy=%b flt=%b rt=%0d rec=%h",
                                 cyc, gt_reset_all, gt_reset_rx_datapath, ready, fault, retries, rx_recoveries,
                                 got_e.c, got_e.gt, got_e.dp, got_e.rdy, got_e.flt, got_e.rt, got_e.rec);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; tx_reset_done = 2'b00; rx_reset_done = 2'b00; rx_aligned = 2'b11;
        // Reset state
        ex(1, 0, 2'b00, 0, 0, 0, 0);
        goto(3);
        reset = 1'b0;

        // Nominal bring-up
        goto(10);
        ex(11, 1, 2'b00, 0, 0, 0, 0);
        ex(15, 0, 2'b00, 0, 0, 0, 0);
        ex(26, 0, 2'b00, 1, 0, 0, 0);
        start = 1'b1;
        goto(11); start = 1'b0;
        goto(20); tx_reset_done = 2'b11;
        goto(25); rx_reset_done = 2'b11;

        // Port-0 recovery, repeating every 12 cycles
        goto(30);
        ex(38, 0, 2'b01, 1, 0, 0, 32'd1);
        ex(42, 0, 2'b00, 1, 0, 0, 32'd1);
        ex(50, 0, 2'b01, 1, 0, 0, 32'd2);
        ex(54, 0, 2'b00, 1, 0, 0, 32'd2);
        rx_aligned = 2'b10;
        goto(52); rx_aligned = 2'b11;

        // Both ports unaligned together
        goto(58);
        ex(66, 0, 2'b11, 1, 0, 0, 32'h0001_0003);
        ex(70, 0, 2'b00, 1, 0, 0, 32'h0001_0003);
        rx_aligned = 2'b00;
        goto(68); rx_aligned = 2'b11;

        // TX loss during a port-1 pulse
        goto(74);
        ex(82, 0, 2'b10, 1, 0, 0, c_R);
        ex(84, 1, 2'b00, 0, 0, 1, c_R);
        ex(88, 0, 2'b00, 0, 0, 1, c_R);
        ex(90, 0, 2'b00, 1, 0, 1, c_R);
        rx_aligned = 2'b01;
        goto(83); tx_reset_done = 2'b00;
        goto(84); tx_reset_done = 2'b11; rx_aligned = 2'b11;

        // Retry then success; TX done lands on the timeout cycle
        goto(94);
        ex(95,  1, 2'b00, 0, 0, 0, c_R);
        ex(99,  0, 2'b00, 0, 0, 0, c_R);
        ex(115, 1, 2'b00, 0, 0, 1, c_R);
        ex(119, 0, 2'b00, 0, 0, 1, c_R);
        ex(136, 0, 2'b00, 1, 0, 1, c_R);
        start = 1'b1; tx_reset_done = 2'b00; rx_reset_done = 2'b00;
        goto(95);  start = 1'b0;
        goto(100); rx_reset_done = 2'b11;
        goto(134); tx_reset_done = 2'b11;

        // Fault after exhausting retries
        goto(140);
        ex(141, 1, 2'b00, 0, 0, 0, c_R);
        ex(145, 0, 2'b00, 0, 0, 0, c_R);
        ex(161, 1, 2'b00, 0, 0, 1, c_R);
        ex(165, 0, 2'b00, 0, 0, 1, c_R);
        ex(181, 1, 2'b00, 0, 0, 2, c_R);
        ex(185, 0, 2'b00, 0, 0, 2, c_R);
        ex(201, 0, 2'b00, 0, 1, 2, c_R);
        start = 1'b1; tx_reset_done = 2'b00; rx_reset_done = 2'b00;
        goto(141); start = 1'b0;

        // Restart from FAULT
        goto(205);
        ex(206, 1, 2'b00, 0, 0, 0, c_R);
        ex(210, 0, 2'b00, 0, 0, 0, c_R);
        ex(212, 0, 2'b00, 1, 0, 0, c_R);
        start = 1'b1; tx_reset_done = 2'b11; rx_reset_done = 2'b11;
        goto(206); start = 1'b0;

        // Reset in the middle of PULSE_ALL
        goto(215);
        ex(216, 1, 2'b00, 0, 0, 0, c_R);
        ex(218, 0, 2'b00, 0, 0, 0, 0);
        start = 1'b1;
        goto(216); start = 1'b0;
        goto(217); reset = 1'b1;
        goto(220); reset = 1'b0;

        goto(230);
        while (exp_q.size() > 0) begin
            got_e = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missing_event got none / required cyc=%0d gt=%b dp=%b rdy=%b flt=%b rt=%0d rec=%h",
                     got_e.c, got_e.gt, got_e.dp, got_e.rdy, got_e.flt, got_e.rt, got_e.rec);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
